// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory stage: access-size encodings,
// MMIO register offsets and the alignment helper.
package dmem_pkg;

  // Core memory-op encodings; unlisted codes behave as a full word.
  typedef enum logic [2:0] {
    MOP_B  = 3'b000,
    MOP_H  = 3'b001,
    MOP_W  = 3'b010,
    MOP_BU = 3'b100,
    MOP_HU = 3'b101
  } mop_e;

  // Byte offsets of the registers inside the 16-byte MMIO window.
  localparam logic [3:0] MMIO_TX     = 4'h0;
  localparam logic [3:0] MMIO_CNT_LO = 4'h4;
  localparam logic [3:0] MMIO_CNT_HI = 4'h8;

  // True when the access size does not fit its natural alignment.
  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] off);
    case (op)
      MOP_B, MOP_BU: return 1'b0;
      MOP_H, MOP_HU: return off[0];
      default:       return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Core-side bus of the data-memory stage plus the TX byte stream.
interface dmem_if;
  logic [31:0] addr;
  logic [31:0] datain;
  logic [2:0]  op;
  logic        we;
  logic [31:0] dataout;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        err;

  modport master (
    output addr, datain, op, we, tx_ready,
    input  dataout, tx_data, tx_valid, err
  );

  modport slave (
    input  addr, datain, op, we, tx_ready,
    output dataout, tx_data, tx_valid, err
  );
endinterface

// File: rtl/dmem_tx_fifo.sv
// Byte FIFO for MMIO character output. Head is shown only once stored
// (no fall-through); a push into a full FIFO is dropped unless a pop
// happens on the same edge, and drops set a sticky overflow flag.
module dmem_tx_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [7:0]                 din,
  input  logic                       pop,
  output logic [7:0]                 dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          ovf;
  logic          do_push, do_pop;

  assign empty    = (cnt == '0);
  assign full     = (cnt == CW'(DEPTH));
  assign count    = cnt;
  assign overflow = ovf;
  assign dout     = empty ? 8'h00 : mem[rd_ptr];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= din;
  end

  // Pointer, occupancy and overflow bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      cnt <= cnt + CW'(1);
      else if (!do_push && do_pop) cnt <= cnt - CW'(1);
      if (push && !do_push) ovf <= 1'b1;
    end
  end
endmodule

// File: rtl/dmem_unit.sv
// Data-memory stage behind the single-cycle core: byte-lane RAM, load
// extension, MMIO TX FIFO and 64-bit cycle counter. Stores land on the
// rising edge, loads are captured on the falling edge of the same cycle.
// Optional macro DMEM_MISALIGN_TRAP_EN suppresses misaligned accesses and
// raises a sticky err; without it err is tied low.
module dmem_unit
  import dmem_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE   = 32'h8010_0000,
  parameter int unsigned DEPTH_WORDS = 32768,
  parameter logic [31:0] MMIO_BASE   = 32'hA000_0000,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);
  localparam int unsigned IW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   ram_off;
  logic          ram_hit, mmio_hit, mis;
  logic [IW-1:0] idx;
  logic [3:0]    mmio_reg;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic          ram_we, tx_push;
  logic [31:0]   mem [DEPTH_WORDS];
  logic [63:0]   cnt_q;
  logic [31:0]   hi_snap_q;
  logic [31:0]   rd_raw, rd_word_q;
  logic [1:0]    rd_off_q;
  logic [2:0]    rd_op_q;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic          fifo_empty, fifo_full, fifo_ovf;
  logic [CW-1:0] fifo_cnt;
  logic [31:0]   tx_status;
  logic          unused_off;

  assign ram_off    = bus.addr - DMEM_BASE;
  assign ram_hit    = (ram_off[31:IW+2] == '0);
  assign idx        = ram_off[IW+1:2];
  assign unused_off = ^ram_off[1:0];
  assign mmio_hit   = (bus.addr[31:4] == MMIO_BASE[31:4]);
  assign mmio_reg   = {bus.addr[3:2], 2'b00};

`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis = misaligned(bus.op, bus.addr[1:0]);
`else
  assign mis = 1'b0;
`endif

  // A store caught by reset is dropped along with everything else.
  assign ram_we  = bus.we && !rst && !mis && ram_hit;
  assign tx_push = bus.we && !rst && !mis && mmio_hit && (mmio_reg == MMIO_TX);

  // Byte enables and lane-replicated store data.
  always_comb begin
    be    = 4'b1111;
    wdata = bus.datain;
    case (bus.op)
      MOP_B: begin
        be    = 4'b0001 << bus.addr[1:0];
        wdata = {4{bus.datain[7:0]}};
      end
      MOP_H: begin
        be    = bus.addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{bus.datain[15:0]}};
      end
      default: ;
    endcase
  end

  // RAM lane writes; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Free-running cycle counter.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_q + 64'd1;
  end

  dmem_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (tx_push),
    .din      (bus.datain[7:0]),
    .pop      (bus.tx_ready),
    .dout     (bus.tx_data),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_cnt),
    .overflow (fifo_ovf)
  );

  assign bus.tx_valid = !fifo_empty;
  assign tx_status    = {24'h0, 4'(fifo_cnt), 1'b0, fifo_ovf, fifo_full, fifo_empty};

  // Raw read word from RAM or MMIO; misses and trapped loads read 0.
  always_comb begin
    rd_raw = '0;
    if (mis) begin
      rd_raw = '0;
    end else if (ram_hit) begin
      rd_raw = mem[idx];
    end else if (mmio_hit) begin
      case (mmio_reg)
        MMIO_TX:     rd_raw = tx_status;
        MMIO_CNT_LO: rd_raw = cnt_q[31:0];
        MMIO_CNT_HI: rd_raw = hi_snap_q;
        default:     rd_raw = '0;
      endcase
    end
  end

  // Falling-edge load capture; a CNT_LO read freezes the upper half so a
  // following CNT_HI read is coherent with it.
  always_ff @(negedge clk) begin
    if (rst) begin
      rd_word_q <= '0;
      rd_off_q  <= '0;
      rd_op_q   <= '0;
      hi_snap_q <= '0;
    end else begin
      rd_word_q <= rd_raw;
      rd_off_q  <= bus.addr[1:0];
      rd_op_q   <= bus.op;
      if (mmio_hit && !mis && (mmio_reg == MMIO_CNT_LO)) hi_snap_q <= cnt_q[63:32];
    end
  end

  // Lane select and extension of the captured word.
  always_comb begin
    ld_byte     = rd_word_q[{rd_off_q, 3'b000} +: 8];
    ld_half     = rd_off_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
    bus.dataout = rd_word_q;
    case (rd_op_q)
      MOP_B:   bus.dataout = {{24{ld_byte[7]}}, ld_byte};
      MOP_BU:  bus.dataout = {24'h0, ld_byte};
      MOP_H:   bus.dataout = {{16{ld_half[15]}}, ld_half};
      MOP_HU:  bus.dataout = {16'h0, ld_half};
      default: ;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic err_q;

  // Sticky: set by any misaligned access, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)      err_q <= 1'b0;
    else if (mis) err_q <= 1'b1;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif
endmodule
